// File: rtl/mux_demux_pkg.sv
// Shared types and constants for the nibble-bus demultiplexer.
`timescale 1ns/1ps
package mux_demux_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_e;

    localparam logic [1:0] PH_HI   = 2'b10;
    localparam logic [1:0] PH_LO   = 2'b01;
    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_BAD  = 2'b11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

endpackage

// File: rtl/frame_filter.sv
// Stability filter: publishes a frame only after STABLE_FRAMES identical
// completions. Compiled only when MUX_DEMUX_STABLE_EN is defined.
`timescale 1ns/1ps
`ifdef MUX_DEMUX_STABLE_EN
module frame_filter #(
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] candidate,
    input  logic       frame_done,
    input  logic       clear,
    output logic [7:0] value,
    output logic       valid
);

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       value_q, value_d;
    logic             valid_q, valid_d;

    always_comb begin
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        value_d = value_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (frame_done) begin
            // A zero count means no previous candidate is trustworthy.
            if (cnt_q != '0 && candidate == prev_q)
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            else
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            prev_d = candidate;
            if (cnt_d >= CNT_MAX && candidate != value_q) begin
                value_d = candidate;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            prev_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;

endmodule
`endif

// File: rtl/mux_demux.sv
// Reassembles bytes from a phased nibble bus. Define MUX_DEMUX_STABLE_EN to
// route completed frames through the frame_filter stability stage.
`timescale 1ns/1ps
module mux_demux
    import mux_demux_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s,
    input  logic [1:0] enable,
    output logic [7:0] value,
    output logic       valid,
    output logic       seq_err,
    output logic [7:0] err_count
);

    if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_param
        $error("mux_demux: STABLE_FRAMES must be in 1..15");
    end

    state_e     state_q, state_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic       seq_err_q, seq_err_d;
    logic [7:0] err_count_q, err_count_d;
    logic       frame_done;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HUNT;
            hi_q        <= '0;
            lo_q        <= '0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (enable == PH_BAD) begin
            state_d = ST_HUNT;
        end else begin
            unique case (state_q)
                ST_HUNT: if (enable == PH_HI) state_d = ST_HI;
                ST_HI:   if (enable == PH_LO) state_d = ST_LO;
                ST_LO:   if (enable == PH_HI) state_d = ST_HI;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        frame_done  = 1'b0;
        seq_err_d   = 1'b0;
        err_count_d = err_count_q;
        unique case (enable)
            PH_HI: begin
                // A high phase after a low phase closes the frame and opens the next.
                frame_done = (state_q == ST_LO);
                hi_d       = s;
            end
            PH_LO: begin
                if (state_q != ST_HUNT) lo_d = s;
            end
            PH_IDLE: begin
                hi_d = hi_q;
            end
            default: begin
                hi_d        = '0;
                lo_d        = '0;
                seq_err_d   = 1'b1;
                err_count_d = sat_inc8(err_count_q);
            end
        endcase
    end

`ifdef MUX_DEMUX_STABLE_EN
    frame_filter #(
        .STABLE_FRAMES(STABLE_FRAMES)
    ) u_frame_filter (
        .clk        (clk),
        .reset      (reset),
        .candidate  ({hi_q, lo_q}),
        .frame_done (frame_done),
        .clear      (seq_err_d),
        .value      (value),
        .valid      (valid)
    );
`else
    logic [7:0] value_q, value_d;
    logic       valid_q;

    assign value_d = frame_done ? {hi_q, lo_q} : value_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            value_q <= value_d;
            valid_q <= frame_done;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
`endif

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mux_demux.sv
// Scoreboard bench for mux_demux; filter scenarios run when MUX_DEMUX_STABLE_EN is defined.
`timescale 1ns/1ps
module tb_mux_demux;

    localparam logic [1:0] EN_HI   = 2'b10;
    localparam logic [1:0] EN_LO   = 2'b01;
    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_BAD  = 2'b11;

    typedef struct {
        logic       vld;
        logic       serr;
        logic [7:0] val;
        logic [7:0] ecnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s = 4'h0;
    logic [1:0] enable = 2'b00;
    logic [7:0] value;
    logic       valid;
    logic       seq_err;
    logic [7:0] err_count;

    int         n_chk = 0;
    int         n_err = 0;
    string      test_name = "reset";
    exp_t       sb[$];
    logic [7:0] exp_value = 8'h00;
    logic [7:0] exp_errs  = 8'h00;

    mux_demux #(.STABLE_FRAMES(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .enable    (enable),
        .value     (value),
        .valid     (valid),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check({test_name, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({test_name, ".valid"},     valid,     e.vld);
        check({test_name, ".seq_err"},   seq_err,   e.serr);
        check({test_name, ".value"},     value,     e.val);
        check({test_name, ".err_count"}, err_count, e.ecnt);
    endtask

    // Drives one sample; the expectation for it is visible one edge later.
    task automatic drive(input logic [1:0] en, input logic [3:0] sv,
                         input logic vld, input logic [7:0] val);
        exp_t e;
        enable = en;
        s      = sv;
        if (vld) exp_value = val;
        if (en == EN_BAD && exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
        e.vld  = vld;
        e.serr = (en == EN_BAD);
        e.val  = exp_value;
        e.ecnt = exp_errs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check({test_name, ".rst_value"},     value,     32'h00);
        check({test_name, ".rst_valid"},     valid,     32'h0);
        check({test_name, ".rst_seq_err"},   seq_err,   32'h0);
        check({test_name, ".rst_err_count"}, err_count, 32'h00);
        exp_value = 8'h00;
        exp_errs  = 8'h00;
        enable    = EN_IDLE;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

`ifdef MUX_DEMUX_STABLE_EN
    logic [7:0] frames [11] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'hA5,
                                8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C};
    logic       fvld   [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic FULL_SEQ_VALID = 1'b0;
`else
    localparam logic FULL_SEQ_VALID = 1'b1;
`endif

    initial begin
        // Power-on reset held for 22 ns.
        #21;
        check("reset.value",     value,     32'h00);
        check("reset.valid",     valid,     32'h0);
        check("reset.seq_err",   seq_err,   32'h0);
        check("reset.err_count", err_count, 32'h00);
        #1;
        reset = 1'b1;
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
        drive(EN_LO,   4'h9, 1'b0, 8'h00);
        drive(EN_HI,   4'h1, 1'b0, 8'h00);

`ifdef MUX_DEMUX_STABLE_EN
        test_name = "filter";
        do_reset();
        drive(EN_HI, frames[0][7:4], 1'b0, 8'h00);
        for (int i = 0; i < 11; i++) begin
            drive(EN_LO, frames[i][3:0], 1'b0, 8'h00);
            drive(EN_HI, (i < 10) ? frames[i+1][7:4] : 4'h0, fvld[i], frames[i]);
        end
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
`else
        test_name = "basic";
        do_reset();
        drive(EN_HI,   4'hA, 1'b0, 8'h00);
        drive(EN_HI,   4'hA, 1'b0, 8'h00);
        drive(EN_LO,   4'h5, 1'b0, 8'h00);
        drive(EN_LO,   4'h5, 1'b0, 8'h00);
        drive(EN_HI,   4'h7, 1'b1, 8'hA5);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
        drive(EN_LO,   4'h5, 1'b0, 8'h00);
        drive(EN_HI,   4'h0, 1'b1, 8'h75);
`endif

        test_name = "illegal";
        drive(EN_HI,   4'hA, 1'b0, 8'h00);
        drive(EN_LO,   4'h5, 1'b0, 8'h00);
        drive(EN_BAD,  4'h0, 1'b0, 8'h00);
        drive(EN_LO,   4'h5, 1'b0, 8'h00);
        drive(EN_HI,   4'hA, 1'b0, 8'h00);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);

`ifndef MUX_DEMUX_STABLE_EN
        test_name = "idle_gaps";
        drive(EN_HI,   4'h3, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) drive(EN_IDLE, 4'hF, 1'b0, 8'h00);
        drive(EN_LO,   4'hC, 1'b0, 8'h00);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
        drive(EN_HI,   4'h6, 1'b1, 8'h3C);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);
`endif

        test_name = "midframe_reset";
        drive(EN_HI, 4'h8, 1'b0, 8'h00);
        drive(EN_LO, 4'h1, 1'b0, 8'h00);
        do_reset();
        drive(EN_LO,   4'h1, 1'b0, 8'h00);
        drive(EN_HI,   4'h2, 1'b0, 8'h00);
        drive(EN_LO,   4'h4, 1'b0, 8'h00);
        drive(EN_HI,   4'h0, FULL_SEQ_VALID, 8'h24);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);

        test_name = "saturate";
        for (int i = 0; i < 300; i++) drive(EN_BAD, 4'h0, 1'b0, 8'h00);
        check("saturate.final", err_count, 32'hFF);
        drive(EN_IDLE, 4'h0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_demux.md
MUX_DEMUX -- requirements
Module: mux_demux

Interface
REQ-001 SHALL have parameter: STABLE_FRAMES, 3, consecutive identical frames required before value updates (filter builds only; legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: s  input  4  time-multiplexed nibble bus.
REQ-005 SHALL have port: enable  input  2  phase select; 2'b10 = high-nibble phase, 2'b01 = low-nibble phase, 2'b00 = idle, 2'b11 = illegal.
REQ-006 SHALL have port: value  output  8  last accepted byte {high, low}.
REQ-007 SHALL have port: valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port: seq_err  output  1  one-cycle pulse on an illegal phase code.
REQ-009 SHALL have port: err_count  output  8  saturating count of seq_err events.

Function
REQ-010 SHALL sample s and enable on every posedge clk; all outputs registered.
REQ-011 SHALL implement FSM states HUNT, HI, LO.
REQ-012 HUNT: enable 10 -> hi_reg<=s, go HI; 01/00 -> stay, discard s.
REQ-013 HI: 10 -> hi_reg<=s (last sample wins); 01 -> lo_reg<=s, go LO; 00 -> stay, hold regs.
REQ-014 LO: 01 -> lo_reg<=s; 10 -> frame complete, candidate={hi_reg,lo_reg}, hi_reg<=s, go HI; 00 -> stay, hold regs.
REQ-015 enable 11 in any state SHALL pulse seq_err next cycle, increment err_count (saturate at 8'hFF), discard partial frame, clear filter count, go HUNT.
REQ-016 Frame completion SHALL drive value and valid the cycle after the LO->HI sample (latency 1 clk).
REQ-017 valid SHALL never be high for two consecutive cycles; a completed frame and seq_err SHALL NOT occur in the same cycle.
REQ-018 A leading LO phase after reset or error SHALL produce no frame.

Reset
REQ-019 reset low SHALL immediately force value=8'h00, valid=0, seq_err=0, err_count=8'h00, hi_reg=lo_reg=0, filter count=0, state HUNT.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame; first valid after release requires a full HI-LO-HI sequence.

Configuration
REQ-021 Macro MUX_DEMUX_STABLE_EN SHALL gate the stability filter.
REQ-022 Without MUX_DEMUX_STABLE_EN: every completed frame SHALL load value and pulse valid, even if unchanged.
REQ-023 With MUX_DEMUX_STABLE_EN: a frame equal to the previous candidate SHALL increment the match count, otherwise reset it to 1. When the count reaches STABLE_FRAMES and candidate != value, value SHALL load and valid SHALL pulse once. The count SHALL saturate.

Structure
REQ-024 Package mux_demux_pkg SHALL hold the state enum and the phase constants PH_HI=2'b10, PH_LO=2'b01, PH_IDLE=2'b00, PH_BAD=2'b11.
REQ-025 The stability filter SHALL be sub-module frame_filter (candidate, frame_done, clear in; value, valid out), instantiated only under MUX_DEMUX_STABLE_EN.

Verification
REQ-026 Bench SHALL cover reset: hold reset low 22 ns then release -> value=00, valid=0, seq_err=0, err_count=00.
REQ-027 Bench SHALL cover basic frame, no macro: HI s=A for 2 clk, LO s=5 for 2 clk, then HI -> value=8'hA5 with a 1-clk valid the cycle after the HI sample.
REQ-028 Bench SHALL cover an illegal phase: enable=11 during LO -> seq_err 1-clk pulse, err_count=1, no valid; a following LO then HI -> no valid.
REQ-029 Bench SHALL cover idle gaps: HI=3, 00 for 3 clk, LO=C, 00, then HI -> value=8'h3C, valid once.
REQ-030 Bench SHALL cover the filter, macro on, STABLE_FRAMES=3: frames A5,A5,A5 -> valid on 3rd only; then A5,3C,A5,A5,A5 -> no valid (value unchanged); then 3C x3 -> value=3C.
REQ-031 Bench SHALL cover saturation: 300 illegal-code cycles -> err_count=8'hFF, not wrapped.
